// File: rtl/sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// sap1_controller_sequencer
//
// Controller-sequencer for the 8-bit SAP-1 datapath. A six-state one-hot ring
// counter (T1..T6) and the instruction opcode are decoded into the 12-bit
// control word. This word drives every load and bus-enable on the W bus.
// The ring either free-runs or advances once per rising edge of STEP in
// manual mode. An HLT instruction freezes the ring at T4 until CLR.
//
// Ports:
//   CLK     in   system clock, all state changes on posedge
//   CLR     in   synchronous active-high reset, also masks the control word
//   opcode  in   IR[7:4], meaningful from T4 onward
//   MANUAL  in   1 = single-step, 0 = free-run
//   STEP    in   debounced step level, rising edge advances in manual mode
//   T       out  one-hot ring state, T[0]=T1 .. T[5]=T6
//   Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo
//           out  control word (n-prefixed signals are active-low)
//   HLT     out  halted flag
// -----------------------------------------------------------------------------
module sap1_controller_sequencer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] opcode,
  input  logic       MANUAL,
  input  logic       STEP,
  output logic [5:0] T,
  output logic       Cp,
  output logic       Ep,
  output logic       nLm,
  output logic       nCE,
  output logic       nLi,
  output logic       nEi,
  output logic       nLa,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       nLb,
  output logic       nLo,
  output logic       HLT
);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] T1_STATE = 6'b000001;

  logic [5:0] t_reg;
  logic [5:0] t_next;
  logic       halt_reg;
  logic       step_reg;
  logic       advance;

  // Rotate left by one position, so T6 wraps back to T1.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_rot
      assign t_next[gi] = t_reg[(gi + 5) % 6];
    end
  endgenerate

  // In manual mode only a 0->1 transition of STEP moves the ring. A held
  // switch therefore yields exactly one T-state.
  assign advance = !MANUAL || (STEP && !step_reg);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      t_reg    <= T1_STATE;
      halt_reg <= 1'b0;
      step_reg <= 1'b0;
    end else begin
      step_reg <= STEP;
      if (!halt_reg && advance) begin
        // HLT is caught on the edge that would leave T4. The ring stays
        // parked at T4 instead of rotating.
        if (t_reg[3] && opcode == OP_HLT) begin
          halt_reg <= 1'b1;
        end else begin
          t_reg <= t_next;
        end
      end
    end
  end

  // Control word decode. Each T-state enables at most one W-bus driver, so
  // the bus is never contended.
  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    nLm = 1'b1;
    nCE = 1'b1;
    nLi = 1'b1;
    nEi = 1'b1;
    nLa = 1'b1;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    nLb = 1'b1;
    nLo = 1'b1;
    if (!CLR && !halt_reg) begin
      // Fetch: PC -> MAR, increment PC, RAM -> IR.
      if (t_reg[0]) begin
        Ep  = 1'b1;
        nLm = 1'b0;
      end
      if (t_reg[1]) begin
        Cp = 1'b1;
      end
      if (t_reg[2]) begin
        nCE = 1'b0;
        nLi = 1'b0;
      end
      // Execute.
      if (t_reg[3]) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            nEi = 1'b0;
            nLm = 1'b0;
          end
          OP_OUT: begin
            Ea  = 1'b1;
            nLo = 1'b0;
          end
          default: ;
        endcase
      end
      if (t_reg[4]) begin
        case (opcode)
          OP_LDA: begin
            nCE = 1'b0;
            nLa = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            nCE = 1'b0;
            nLb = 1'b0;
          end
          default: ;
        endcase
      end
      if (t_reg[5]) begin
        case (opcode)
          OP_ADD, OP_SUB: begin
            Eu  = 1'b1;
            nLa = 1'b0;
            Su  = (opcode == OP_SUB);
          end
          default: ;
        endcase
      end
    end
  end

  assign T   = t_reg;
  assign HLT = halt_reg;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap1_controller_sequencer
//
// Self-checking bench for the SAP-1 controller-sequencer. The reference model
// tracks the instruction phase as an integer index 0..5, plus a halted bit
// and the previous STEP level. The expected control word comes from the
// per-phase instruction table.
// -----------------------------------------------------------------------------
module tb_sap1_controller_sequencer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       MANUAL = 1'b0;
  logic       STEP = 1'b0;
  logic [5:0] T;
  logic       Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_idx  = 0;
  bit m_halt = 1'b0;
  bit m_prev = 1'b0;

  always #5 CLK = ~CLK;

  sap1_controller_sequencer dut (
    .CLK(CLK), .CLR(CLR), .opcode(opcode), .MANUAL(MANUAL), .STEP(STEP),
    .T(T), .Cp(Cp), .Ep(Ep), .nLm(nLm), .nCE(nCE), .nLi(nLi), .nEi(nEi),
    .nLa(nLa), .Ea(Ea), .Su(Su), .Eu(Eu), .nLb(nLb), .nLo(nLo), .HLT(HLT)
  );

  // Word order: {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}
  function automatic logic [11:0] exp_word(int idx, logic [3:0] op, bit clr, bit halt);
    logic cp = 0, ep = 0, nlm = 1, nce = 1, nli = 1, nei = 1;
    logic nla = 1, ea = 0, su = 0, eu = 0, nlb = 1, nlo = 1;
    bit   mem_op = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
    bit   alu_op = (op == 4'h1) || (op == 4'h2);
    if (!clr && !halt) begin
      case (idx)
        0: begin ep = 1; nlm = 0; end
        1: cp = 1;
        2: begin nce = 0; nli = 0; end
        3: begin
          if (mem_op) begin nei = 0; nlm = 0; end
          else if (op == 4'hE) begin ea = 1; nlo = 0; end
        end
        4: begin
          if (op == 4'h0) begin nce = 0; nla = 0; end
          else if (alu_op) begin nce = 0; nlb = 0; end
        end
        5: begin
          if (alu_op) begin eu = 1; nla = 0; su = (op == 4'h2); end
        end
        default: ;
      endcase
    end
    return {cp, ep, nlm, nce, nli, nei, nla, ea, su, eu, nlb, nlo};
  endfunction

  task automatic check(string tag, logic [11:0] obs, logic [11:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_now();
    logic [11:0] w;
    logic [5:0]  t_exp;
    int          drivers;
    w       = {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo};
    t_exp   = 6'(1 << m_idx);
    drivers = int'(Ep) + int'(Ea) + int'(Eu) + int'(!nCE) + int'(!nEi);
    check("T", 12'(T), 12'(t_exp));
    check("HLT", 12'(HLT), 12'(m_halt));
    check("ctrl_word", w, exp_word(m_idx, opcode, CLR, m_halt));
    check("bus_conflict", 12'(drivers <= 1), 12'd1);
  endtask

  // One clock: apply inputs, check outputs, take the edge, update the model.
  task automatic cycle(bit clr, bit man, bit stp, logic [3:0] op);
    bit adv;
    CLR    = clr;
    MANUAL = man;
    STEP   = stp;
    opcode = op;
    #1;
    check_now();
    @(posedge CLK);
    if (clr) begin
      m_idx  = 0;
      m_halt = 1'b0;
      m_prev = 1'b0;
    end else begin
      adv    = !man || (stp && !m_prev);
      m_prev = stp;
      if (!m_halt && adv) begin
        if (m_idx == 3 && op == 4'hF) m_halt = 1'b1;
        else m_idx = (m_idx + 1) % 6;
      end
    end
    $display("cyc clr=%0b man=%0b step=%0b op=%h -> model T%0d halt=%0b",
             clr, man, stp, op, m_idx + 1, m_halt);
    #1;
  endtask

  initial begin
    // Bring the DUT out of its unknown power-up state before any checking.
    @(posedge CLK);
    #1;

    // 1: reset for two cycles, then free-run LDA.
    cycle(1, 0, 0, 4'h0);
    cycle(1, 0, 0, 4'h0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 4'h0);

    // 2: SUB then ADD (the ring is at T2 here; run to T1 first).
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 4'h0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 4'h2);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 4'h1);

    // 3: OUT.
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 4'hE);

    // 4: HLT, then hold for 20 cycles with STEP/MANUAL toggling, then clear.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 4'hF);
    for (int i = 0; i < 20; i++) cycle(0, i[0], i[1], 4'hF);
    cycle(1, 0, 0, 4'hF);
    cycle(0, 0, 0, 4'h0);

    // 5: manual mode; STEP high 10, low 3, high 3.
    cycle(1, 0, 0, 4'h0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 4'h1);
    for (int i = 0; i < 3; i++)  cycle(0, 1, 0, 4'h1);
    for (int i = 0; i < 3; i++)  cycle(0, 1, 1, 4'h1);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1'($urandom_range(0, 1)), 4'h1);

    // 6: CLR during T5 of ADD, then all 16 opcodes free-run.
    cycle(1, 0, 0, 4'h1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 4'h1);
    cycle(1, 0, 0, 4'h1);
    cycle(0, 0, 0, 4'h1);
    cycle(1, 0, 0, 4'h0);
    for (int op = 0; op < 16; op++) begin
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 4'(op));
    end

    // Randomized mix of everything.
    cycle(1, 0, 0, 4'h0);
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
